ec_point_decoder: RTL and testbench
===================================

Name: ec_point_decoder

Overview:
- Hardware parser for SEC1-encoded EC public-key points. It is the receive side of the point-export path, which emits 0x04||X||Y with coordinates padded to the curve size.
- Consumes a byte stream, validates the prefix and length against the selected curve, and splits it into right-aligned X/Y coordinates plus format flags.
- Sits between the key-import byte interface and the EC arithmetic core.

Parameters:
- MAX_COORD_BYTES, 66, largest coordinate size supported (P-521); sets coordinate output width.
- CW, 8*MAX_COORD_BYTES, coordinate output width in bits (derived; do not override).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- curve_sel  in  2  0=P-256 (32B), 1=P-384 (48B), 2=P-521 (66B), 3=secp256k1 (32B); sampled on prefix acceptance
- s_valid  in  1  input byte valid
- s_ready  out  1  decoder accepts byte
- s_data  in  8  encoded byte, first byte = prefix
- s_last  in  1  final byte of encoding
- m_valid  out  1  decoded result valid
- m_ready  in  1  consumer accepts result
- m_x  out  CW  X coordinate, big-endian, zero-extended (right-aligned)
- m_y  out  CW  Y coordinate, zero for compressed formats
- m_fmt  out  2  0=compressed, 1=uncompressed, 2=hybrid
- m_y_parity  out  1  prefix LSB (0x02/0x06 -> 0, 0x03/0x07 -> 1); 0 for uncompressed
- m_err  out  1  frame rejected; m_x/m_y are don't-care when set
- m_err_code  out  3  0 none, 1 bad prefix, 2 short frame, 3 long frame, 4 hybrid parity mismatch

Behaviour:
- Reset: state IDLE; s_ready=1; m_valid=0; m_x=m_y=0; m_fmt=0; m_y_parity=0; m_err=0; m_err_code=0; byte counter=0.
- A byte transfers when s_valid && s_ready. A result transfers when m_valid && m_ready.
- States: IDLE, X, Y, DRAIN, DONE. s_ready=1 in every state except DONE.
- IDLE (prefix byte):
  - Latch the coordinate size L from curve_sel and clear the shift registers.
  - Prefix 0x02/0x03 -> X, m_fmt=0. Prefix 0x04 -> X, m_fmt=1. Prefix 0x06/0x07 -> X, m_fmt=2.
  - Any other prefix, including 0x00 (point at infinity): err 1. With s_last -> DONE, else -> DRAIN.
  - Valid prefix with s_last: err 2 -> DONE.
- X: each byte shifts into m_x (left shift by 8, new byte in LSBs), counter++. The counter wraps to 0 at L.
  - Byte L with compressed format: s_last -> DONE ok; otherwise err 3 -> DRAIN.
  - Byte L with uncompressed/hybrid format: s_last -> err 2 -> DONE; otherwise -> Y.
  - s_last before byte L: err 2 -> DONE.
- Y: same shifting into m_y.
  - Byte L with s_last -> DONE. For hybrid, compare the new byte's bit0 with m_y_parity; a mismatch gives err 4.
  - Byte L without s_last: err 3 -> DRAIN.
  - Earlier s_last: err 2 -> DONE.
- DRAIN: accept and discard bytes until s_last, then -> DONE. The error code latched on entry is kept.
- DONE: m_valid=1, outputs stable. On m_ready -> IDLE (m_valid=0 the following cycle). While in DONE, s_ready=0 so input is back-pressured.
- Latency: m_valid rises the cycle after the final byte is accepted. Best-case throughput is one frame per (2L+1)+1 cycles; there is no overlap between the result hold and the next prefix.
- m_err_code reports only the first error per frame.
- curve_sel changes mid-frame are ignored.
- rst mid-frame returns to IDLE immediately. Leftover bytes from the upstream frame are then parsed as a new frame (the first is taken as a prefix); upstream must flush on reset.
- Coordinates are not range-checked against the field prime, and no on-curve check is done; the arithmetic core owns both.

Decomposition:
- Package ec_point_pkg:
  - curve_sel enum
  - coordinate-byte lookup function (32/48/66/32)
  - prefix constants 0x02, 0x03, 0x04, 0x06, 0x07
  - fmt enum
  - err_code enum
  - state enum
- Single module, no sub-modules. The two shift registers and the counter are small enough to inline.

Test Plan:
- P-256, 0x04 followed by X=0x01..0x20 and Y=0x21..0x40 (65 bytes, s_last on the final byte) -> m_x LSBs = 0x0102..20, upper 34 bytes zero; m_fmt=1; m_err=0; m_valid on the cycle after the last byte.
- P-384, 0x03 followed by 48 bytes of 0xAA -> m_fmt=0, m_y_parity=1, m_y=0, m_err=0.
- P-256, 0x06 followed by 32 bytes X and a Y whose last byte is 0x01 -> m_err=1, code 4. Repeat with last byte 0x02 -> m_err=0, m_fmt=2.
- Prefix 0x05 followed by 10 bytes, s_last on the 11th -> all 11 bytes accepted (drained), m_err code 1, then IDLE.
- P-521, 0x04 followed by 100 bytes (s_last early) -> code 2. Then 0x04 followed by 134 bytes -> code 3, with drain until s_last.
- m_ready held low for 20 cycles in DONE with s_valid=1 -> s_ready=0 and outputs stable throughout. Separately, pulse rst during the X phase -> all outputs at reset values and the next byte is treated as a prefix.

Source files
------------

// File: rtl/ec_point_pkg.sv
// Shared types and constants for the SEC1 EC point decoder.
package ec_point_pkg;

   localparam int unsigned CNT_W = 7;

   typedef enum logic [1:0] {
      CURVE_P256 = 2'd0,
      CURVE_P384 = 2'd1,
      CURVE_P521 = 2'd2,
      CURVE_K256 = 2'd3
   } curve_e;

   typedef enum logic [1:0] {
      FMT_COMP   = 2'd0,
      FMT_UNCOMP = 2'd1,
      FMT_HYBRID = 2'd2
   } fmt_e;

   typedef enum logic [2:0] {
      ERR_NONE   = 3'd0,
      ERR_PREFIX = 3'd1,
      ERR_SHORT  = 3'd2,
      ERR_LONG   = 3'd3,
      ERR_PARITY = 3'd4
   } err_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_X     = 3'd1,
      ST_Y     = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   localparam logic [7:0] PFX_COMP_EVEN = 8'h02;
   localparam logic [7:0] PFX_COMP_ODD  = 8'h03;
   localparam logic [7:0] PFX_UNCOMP    = 8'h04;
   localparam logic [7:0] PFX_HYB_EVEN  = 8'h06;
   localparam logic [7:0] PFX_HYB_ODD   = 8'h07;

   // Coordinate length in bytes for each supported curve.
   function automatic logic [CNT_W-1:0] coord_bytes(input curve_e c);
      case (c)
         CURVE_P256: return CNT_W'(32);
         CURVE_P384: return CNT_W'(48);
         CURVE_P521: return CNT_W'(66);
         default:    return CNT_W'(32);
      endcase
   endfunction

endpackage

// File: rtl/ec_point_decoder.sv
// SEC1 point parser: validates prefix/length against the selected curve and
// splits the byte stream into right-aligned X/Y coordinates.
module ec_point_decoder
   import ec_point_pkg::*;
#(
   parameter  int unsigned MAX_COORD_BYTES = 66,
   localparam int unsigned CW              = 8 * MAX_COORD_BYTES
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    curve_sel,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [7:0]    s_data,
   input  logic          s_last,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [CW-1:0] m_x,
   output logic [CW-1:0] m_y,
   output logic [1:0]    m_fmt,
   output logic          m_y_parity,
   output logic          m_err,
   output logic [2:0]    m_err_code
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic [CW-1:0]    x_q, x_d;
   logic [CW-1:0]    y_q, y_d;
   fmt_e             fmt_q, fmt_d;
   logic             par_q, par_d;
   err_e             code_q, code_d;
   logic             err_q;
   logic             s_ready_q;
   logic             m_valid_q;
   logic             acc;
   logic             coord_end;

   assign acc       = s_valid && s_ready_q;
   assign coord_end = (cnt_q == (len_q - CNT_W'(1)));

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      x_d     = x_q;
      y_d     = y_q;
      fmt_d   = fmt_q;
      par_d   = par_q;
      code_d  = code_q;
      case (state_q)
         ST_IDLE: if (acc) begin
            len_d  = coord_bytes(curve_e'(curve_sel));
            x_d    = '0;
            y_d    = '0;
            cnt_d  = '0;
            code_d = ERR_NONE;
            fmt_d  = FMT_COMP;
            par_d  = 1'b0;
            case (s_data)
               PFX_COMP_EVEN, PFX_COMP_ODD: begin
                  par_d   = s_data[0];
                  state_d = ST_X;
               end
               PFX_UNCOMP: begin
                  fmt_d   = FMT_UNCOMP;
                  state_d = ST_X;
               end
               PFX_HYB_EVEN, PFX_HYB_ODD: begin
                  fmt_d   = FMT_HYBRID;
                  par_d   = s_data[0];
                  state_d = ST_X;
               end
               default: begin
                  code_d  = ERR_PREFIX;
                  state_d = s_last ? ST_DONE : ST_DRAIN;
               end
            endcase
            if ((code_d == ERR_NONE) && s_last) begin
               code_d  = ERR_SHORT;
               state_d = ST_DONE;
            end
         end
         ST_X: if (acc) begin
            x_d   = {x_q[CW-9:0], s_data};
            cnt_d = coord_end ? '0 : cnt_q + CNT_W'(1);
            if (coord_end) begin
               if (fmt_q == FMT_COMP) begin
                  if (s_last) state_d = ST_DONE;
                  else begin
                     code_d  = ERR_LONG;
                     state_d = ST_DRAIN;
                  end
               end else if (s_last) begin
                  code_d  = ERR_SHORT;
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_Y;
               end
            end else if (s_last) begin
               code_d  = ERR_SHORT;
               state_d = ST_DONE;
            end
         end
         ST_Y: if (acc) begin
            y_d   = {y_q[CW-9:0], s_data};
            cnt_d = coord_end ? '0 : cnt_q + CNT_W'(1);
            if (coord_end && s_last) begin
               state_d = ST_DONE;
               if ((fmt_q == FMT_HYBRID) && (s_data[0] != par_q)) code_d = ERR_PARITY;
            end else if (coord_end) begin
               code_d  = ERR_LONG;
               state_d = ST_DRAIN;
            end else if (s_last) begin
               code_d  = ERR_SHORT;
               state_d = ST_DONE;
            end
         end
         ST_DRAIN: if (acc && s_last) state_d = ST_DONE;
         ST_DONE:  if (m_ready) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         len_q     <= '0;
         x_q       <= '0;
         y_q       <= '0;
         fmt_q     <= FMT_COMP;
         par_q     <= 1'b0;
         code_q    <= ERR_NONE;
         err_q     <= 1'b0;
         s_ready_q <= 1'b1;
         m_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         len_q     <= len_d;
         x_q       <= x_d;
         y_q       <= y_d;
         fmt_q     <= fmt_d;
         par_q     <= par_d;
         code_q    <= code_d;
         err_q     <= (code_d != ERR_NONE);
         s_ready_q <= (state_d != ST_DONE);
         m_valid_q <= (state_d == ST_DONE);
      end
   end

   assign s_ready    = s_ready_q;
   assign m_valid    = m_valid_q;
   assign m_x        = x_q;
   assign m_y        = y_q;
   assign m_fmt      = fmt_q;
   assign m_y_parity = par_q;
   assign m_err      = err_q;
   assign m_err_code = code_q;

endmodule

// File: tb/tb_ec_point_decoder.sv
// Directed vector bench for ec_point_decoder.
module tb_ec_point_decoder;

   localparam int unsigned CW = 528;

   localparam logic [255:0] X_INC = 256'h0102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f20;
   localparam logic [255:0] Y_INC = 256'h2122232425262728292a2b2c2d2e2f303132333435363738393a3b3c3d3e3f40;
   localparam logic [255:0] Y_E02 = 256'h2122232425262728292a2b2c2d2e2f303132333435363738393a3b3c3d3e3f02;
   localparam logic [255:0] Y_E41 = 256'h2122232425262728292a2b2c2d2e2f303132333435363738393a3b3c3d3e3f41;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [1:0]    curve_sel = 2'd0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [7:0]    s_data = 8'h00;
   logic          s_last = 1'b0;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [CW-1:0] m_x;
   logic [CW-1:0] m_y;
   logic [1:0]    m_fmt;
   logic          m_y_parity;
   logic          m_err;
   logic [2:0]    m_err_code;

   int checks = 0;
   int errors = 0;

   ec_point_decoder dut (
      .clk(clk), .rst(rst), .curve_sel(curve_sel),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .m_valid(m_valid), .m_ready(m_ready), .m_x(m_x), .m_y(m_y),
      .m_fmt(m_fmt), .m_y_parity(m_y_parity), .m_err(m_err), .m_err_code(m_err_code)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]    curve;
      logic [7:0]    prefix;
      int            n_body;
      logic [7:0]    base;
      bit            incr;
      bit            ovr_en;
      logic [7:0]    ovr;
      logic [1:0]    fmt;
      bit            par;
      logic [2:0]    code;
      bit            chk_xy;
      logic [CW-1:0] x;
      logic [CW-1:0] y;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic chk_w(input string name, input logic [CW-1:0] got, input logic [CW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the byte is taken.
   task automatic put_byte(input logic [7:0] d, input logic l, output int stall);
      stall   = 0;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      while (!s_ready && stall < 100) begin
         @(negedge clk);
         stall++;
      end
      if (!s_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: byte %0h not accepted after %0d cycles", d, stall);
      end
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input bit hold, input int idx);
      int         total;
      int         stall;
      int         stalls;
      logic [7:0] b;
      total  = v.n_body + 1;
      stalls = 0;
      curve_sel = v.curve;
      for (int i = 0; i < total; i++) begin
         if (i == 0) b = v.prefix;
         else b = v.incr ? v.base + 8'(i - 1) : v.base;
         if (i == total - 1 && i != 0 && v.ovr_en) b = v.ovr;
         put_byte(b, (i == total - 1), stall);
         stalls += stall;
         if (i == 0) curve_sel = ~v.curve;
      end
      chk($sformatf("v%0d_stalls", idx), 32'(stalls), 32'd0);
      chk($sformatf("v%0d_valid", idx), 32'(m_valid), 32'd1);
      chk($sformatf("v%0d_err", idx), 32'(m_err), 32'(v.code != 3'd0));
      chk($sformatf("v%0d_code", idx), 32'(m_err_code), 32'(v.code));
      if (v.code == 3'd0) begin
         chk($sformatf("v%0d_fmt", idx), 32'(m_fmt), 32'(v.fmt));
         chk($sformatf("v%0d_par", idx), 32'(m_y_parity), 32'(v.par));
         if (v.chk_xy) begin
            chk_w($sformatf("v%0d_x", idx), m_x, v.x);
            chk_w($sformatf("v%0d_y", idx), m_y, v.y);
         end
      end
      if (!hold) begin
         m_ready = 1'b1;
         @(negedge clk);
         chk($sformatf("v%0d_release", idx), 32'(m_valid), 32'd0);
         m_ready = 1'b0;
      end
   endtask

   initial begin
      int st;
      //           curve  pfx    body base   inc   ovr   ov     fmt   par   code  xy    x                          y
      vecs[0]  = '{2'd0, 8'h04, 64,  8'h01, 1'b1, 1'b0, 8'h00, 2'd1, 1'b0, 3'd0, 1'b1, CW'(X_INC),                CW'(Y_INC)};
      vecs[1]  = '{2'd1, 8'h03, 48,  8'hAA, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 3'd0, 1'b1, CW'({48{8'hAA}}),         CW'(0)};
      vecs[2]  = '{2'd0, 8'h06, 64,  8'h01, 1'b1, 1'b1, 8'h01, 2'd2, 1'b0, 3'd4, 1'b0, CW'(0),                   CW'(0)};
      vecs[3]  = '{2'd0, 8'h06, 64,  8'h01, 1'b1, 1'b1, 8'h02, 2'd2, 1'b0, 3'd0, 1'b1, CW'(X_INC),                CW'(Y_E02)};
      vecs[4]  = '{2'd0, 8'h05, 10,  8'h11, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 3'd1, 1'b0, CW'(0),                   CW'(0)};
      vecs[5]  = '{2'd2, 8'h04, 100, 8'h01, 1'b1, 1'b0, 8'h00, 2'd1, 1'b0, 3'd2, 1'b0, CW'(0),                   CW'(0)};
      vecs[6]  = '{2'd2, 8'h04, 134, 8'h01, 1'b1, 1'b0, 8'h00, 2'd1, 1'b0, 3'd3, 1'b0, CW'(0),                   CW'(0)};
      vecs[7]  = '{2'd0, 8'h02, 32,  8'h5A, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 3'd0, 1'b1, CW'({32{8'h5A}}),         CW'(0)};
      vecs[8]  = '{2'd3, 8'h07, 64,  8'h01, 1'b1, 1'b1, 8'h41, 2'd2, 1'b1, 3'd0, 1'b1, CW'(X_INC),                CW'(Y_E41)};
      vecs[9]  = '{2'd0, 8'h02, 33,  8'h10, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 3'd3, 1'b0, CW'(0),                   CW'(0)};
      vecs[10] = '{2'd0, 8'h04, 0,   8'h00, 1'b0, 1'b0, 8'h00, 2'd1, 1'b0, 3'd2, 1'b0, CW'(0),                   CW'(0)};
      vecs[11] = '{2'd0, 8'h00, 0,   8'h00, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 3'd1, 1'b0, CW'(0),                   CW'(0)};
      vecs[12] = '{2'd1, 8'h03, 31,  8'h22, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 3'd2, 1'b0, CW'(0),                   CW'(0)};
      vecs[13] = '{2'd0, 8'h04, 32,  8'h33, 1'b0, 1'b0, 8'h00, 2'd1, 1'b0, 3'd2, 1'b0, CW'(0),                   CW'(0)};
      vecs[14] = '{2'd2, 8'h04, 132, 8'h01, 1'b1, 1'b0, 8'h00, 2'd1, 1'b0, 3'd0, 1'b0, CW'(0),                   CW'(0)};
      vecs[15] = '{2'd2, 8'h02, 66,  8'hFF, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 3'd0, 1'b1, CW'({66{8'hFF}}),         CW'(0)};

      repeat (2) @(negedge clk);
      chk("rst_s_ready", 32'(s_ready), 32'd1);
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk_w("rst_m_x", m_x, '0);
      chk_w("rst_m_y", m_y, '0);
      chk("rst_m_err", 32'({m_fmt, m_y_parity, m_err, m_err_code}), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 16; i++) run_vec(vecs[i], 1'b0, i);

      // Hold the result while upstream keeps offering bytes.
      run_vec(vecs[7], 1'b1, 100);
      s_valid = 1'b1;
      s_data  = 8'h04;
      s_last  = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk($sformatf("hold%0d_s_ready", c), 32'(s_ready), 32'd0);
         chk($sformatf("hold%0d_m_valid", c), 32'(m_valid), 32'd1);
         chk_w($sformatf("hold%0d_m_x", c), m_x, CW'({32{8'h5A}}));
         chk($sformatf("hold%0d_flags", c), 32'({m_fmt, m_err, m_err_code}), 32'd0);
      end
      s_valid = 1'b0;
      m_ready = 1'b1;
      @(negedge clk);
      chk("hold_release_valid", 32'(m_valid), 32'd0);
      chk("hold_release_ready", 32'(s_ready), 32'd1);
      m_ready = 1'b0;

      // Reset partway through the X coordinate.
      curve_sel = 2'd0;
      put_byte(8'h04, 1'b0, st);
      for (int k = 0; k < 10; k++) put_byte(8'h80 + 8'(k), 1'b0, st);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_s_ready", 32'(s_ready), 32'd1);
      chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
      chk_w("mid_rst_m_x", m_x, '0);
      chk_w("mid_rst_m_y", m_y, '0);
      chk("mid_rst_flags", 32'({m_fmt, m_y_parity, m_err, m_err_code}), 32'd0);
      rst = 1'b0;
      run_vec(vecs[7], 1'b0, 200);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
